sram_responder: RTL

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// Purpose : single-outstanding SRAM-style responder: read and write request channels on the front side, one-beat memory port on the back side.
// Latency : response valid exactly LATENCY cycles after the accepting edge (plus 0..3 random cycles when SRAM_RESP_RAND_DELAY_EN is defined).
// Backpr. : no new request is accepted until the response handshake completes; rvalid/bvalid and their payload are held until rready/bready.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   araddr/arvalid/arready        read request
//   rdata/rresp/rvalid/rready     read response (rresp 2'b11 = decode error)
//   awaddr/wdata/wstrb/awvalid/awready  write request, address and data together
//   bresp/bvalid/bready           write response (bresp 2'b11 = decode error)
//   pmem_*                        backing memory: one pmem_rd_en or pmem_wr_en pulse per
//                                 in-range transaction, issued on the final wait cycle.
//                                 pmem_rdata is sampled on the edge ending that cycle.
// Build option: define SRAM_RESP_RAND_DELAY_EN to add the LFSR-driven random extra delay.
module sram_responder #(
    parameter int unsigned LATENCY = 1,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter logic [31:0] SIZE    = 32'h0800_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        awvalid,
    output logic        awready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    output logic        pmem_rd_en,
    output logic        pmem_wr_en,
    output logic [31:0] pmem_addr,
    output logic [31:0] pmem_wdata,
    output logic [7:0]  pmem_wmask,
    input  logic [31:0] pmem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_WAIT = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    localparam logic [4:0] LAT_M1 = 5'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  load_val;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        rd_accept, wr_accept;
    logic        rd_exit, wr_exit;
    logic        in_range;

    // 33-bit compare so BASE+SIZE reaching 2^32 cannot wrap.
    logic [32:0] addr_ext, base_ext, top_ext;
    assign addr_ext = {1'b0, addr_q};
    assign base_ext = {1'b0, BASE};
    assign top_ext  = {1'b0, BASE} + {1'b0, SIZE};
    assign in_range = (addr_ext >= base_ext) && (addr_ext < top_ext);

`ifdef SRAM_RESP_RAND_DELAY_EN
    // x^4+x^3+1 Fibonacci LFSR; the value before each acceptance sets the extra delay.
    logic [3:0] lfsr_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= 4'b1001;
        end else if (rd_accept || wr_accept) begin
            lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        end
    end
    assign load_val = LAT_M1 + {3'b000, lfsr_q[1:0]};
`else
    assign load_val = LAT_M1;
`endif

    // Ready only in IDLE and never while reset is asserted; reads win over writes.
    assign arready = rst && (state_q == IDLE);
    assign awready = rst && (state_q == IDLE) && !arvalid;

    assign rd_exit = (state_q == RD_WAIT) && (cnt_q == 5'd0);
    assign wr_exit = (state_q == WR_WAIT) && (cnt_q == 5'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_accept = 1'b0;
        wr_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (arvalid) begin
                    rd_accept = 1'b1;
                    cnt_d     = load_val;
                    state_d   = RD_WAIT;
                end else if (awvalid) begin
                    wr_accept = 1'b1;
                    cnt_d     = load_val;
                    state_d   = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 5'd0) state_d = RD_RESP;
                else               cnt_d   = cnt_q - 5'd1;
            end
            RD_RESP: begin
                if (rready) state_d = IDLE;
            end
            WR_WAIT: begin
                if (cnt_q == 5'd0) state_d = WR_RESP;
                else               cnt_d   = cnt_q - 5'd1;
            end
            WR_RESP: begin
                if (bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture: later changes on the request inputs do not affect the transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
        end else if (rd_accept) begin
            addr_q  <= araddr;
        end else if (wr_accept) begin
            addr_q  <= awaddr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
        end
    end

    // Response registers: payload is only loaded on the wait-exit edge, so it holds in *_RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= 1'b0;
            rdata  <= 32'd0;
            rresp  <= 2'b00;
            bvalid <= 1'b0;
            bresp  <= 2'b00;
        end else begin
            if (rd_exit) begin
                rvalid <= 1'b1;
                rdata  <= in_range ? pmem_rdata : 32'd0;
                rresp  <= in_range ? 2'b00 : 2'b11;
            end else if ((state_q == RD_RESP) && rready) begin
                rvalid <= 1'b0;
            end
            if (wr_exit) begin
                bvalid <= 1'b1;
                bresp  <= in_range ? 2'b00 : 2'b11;
            end else if ((state_q == WR_RESP) && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Memory side: a single-cycle strobe on the last wait cycle, suppressed for decode errors.
    assign pmem_rd_en = rd_exit && in_range;
    assign pmem_wr_en = wr_exit && in_range;
    assign pmem_addr  = {addr_q[31:2], 2'b00};
    assign pmem_wdata = wdata_q;
    assign pmem_wmask = {4'b0000, wstrb_q};

endmodule
